// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared widths, output type and default fault settings for the 4-to-16 decoder
package dec_pkg;
    localparam int SEL_W   = 4;
    localparam int OUT_W   = 16;
    localparam int SLICE_W = 8;

    typedef logic [OUT_W-1:0] dec_out_t;

    localparam int DEF_FAULT_ON  = 1;
    localparam int DEF_FAULT_IDX = 8;
    localparam int DEF_FAULT_VAL = 0;
endpackage

// File: rtl/dec_4x16_fault8_if.sv
// rtl/dec_4x16_fault8_if.sv - select inputs and decoded outputs; fault_flag exists only with DEC_FAULT_DETECT_EN
interface dec_4x16_fault8_if;
    import dec_pkg::*;

    logic     X;
    logic     Y;
    logic     Z;
    logic     W;
    dec_out_t D;
`ifdef DEC_FAULT_DETECT_EN
    logic     fault_flag;
`endif

    modport master (
        output X, Y, Z, W,
`ifdef DEC_FAULT_DETECT_EN
        input  fault_flag,
`endif
        input  D
    );

    modport slave (
        input  X, Y, Z, W,
`ifdef DEC_FAULT_DETECT_EN
        output fault_flag,
`endif
        output D
    );
endinterface

// File: rtl/dec_3x8.sv
// rtl/dec_3x8.sv - combinational 3-to-8 one-hot decoder slice; all zeros when disabled
module dec_3x8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        if (en) begin
            y = 8'h01 << a;
        end
    end
endmodule

// File: rtl/dec_4x16_fault8.sv
// rtl/dec_4x16_fault8.sv - registered 4-to-16 decoder with a stuck-at fault overlay; DEC_FAULT_DETECT_EN adds fault_flag
module dec_4x16_fault8
    import dec_pkg::*;
#(
    parameter int FAULT_ON  = DEF_FAULT_ON,
    parameter int FAULT_IDX = DEF_FAULT_IDX,
    parameter int FAULT_VAL = DEF_FAULT_VAL
) (
    input  logic                 clk,
    input  logic                 rst,
    dec_4x16_fault8_if.slave     bus
);
    // An out-of-range index disables the fault entirely rather than wrapping.
    localparam bit         FAULT_ACTIVE = (FAULT_ON != 0) && (FAULT_IDX >= 0) && (FAULT_IDX < OUT_W);
    localparam logic [3:0] FAULT_BIT    = FAULT_IDX[3:0];
    localparam logic       FAULT_BITVAL = (FAULT_VAL != 0);

    logic [SEL_W-1:0]   sel;
    logic [SLICE_W-1:0] lo_y;
    logic [SLICE_W-1:0] hi_y;
    dec_out_t           golden;
    dec_out_t           faulty;

    assign sel = {bus.X, bus.Y, bus.Z, bus.W};

    dec_3x8 u_lo (
        .en (~sel[3]),
        .a  (sel[2:0]),
        .y  (lo_y)
    );

    dec_3x8 u_hi (
        .en (sel[3]),
        .a  (sel[2:0]),
        .y  (hi_y)
    );

    assign golden = {hi_y, lo_y};

    always_comb begin
        faulty = golden;
        if (FAULT_ACTIVE) begin
            faulty[FAULT_BIT] = FAULT_BITVAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.D <= '0;
        end else begin
            bus.D <= faulty;
        end
    end

`ifdef DEC_FAULT_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fault_flag <= 1'b0;
        end else begin
            bus.fault_flag <= (faulty != golden);
        end
    end
`endif
endmodule

// File: tb/tb_dec_4x16_fault8.sv
// tb/tb_dec_4x16_fault8.sv - randomized self-checking bench over four fault configurations
module tb_dec_4x16_fault8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dec_4x16_fault8_if if_def ();
    dec_4x16_fault8_if if_off ();
    dec_4x16_fault8_if if_one ();
    dec_4x16_fault8_if if_oor ();

    dec_4x16_fault8 u_def (.clk(clk), .rst(rst), .bus(if_def.slave));
    dec_4x16_fault8 #(.FAULT_ON(0), .FAULT_IDX(8), .FAULT_VAL(0)) u_off (.clk(clk), .rst(rst), .bus(if_off.slave));
    dec_4x16_fault8 #(.FAULT_ON(1), .FAULT_IDX(8), .FAULT_VAL(1)) u_one (.clk(clk), .rst(rst), .bus(if_one.slave));
    dec_4x16_fault8 #(.FAULT_ON(1), .FAULT_IDX(20), .FAULT_VAL(0)) u_oor (.clk(clk), .rst(rst), .bus(if_oor.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] golden_of(input int sel);
        return 16'(1 << sel);
    endfunction

    function automatic logic [15:0] model(input int sel, input int on, input int idx, input int val);
        logic [15:0] r;
        r = golden_of(sel);
        if (on != 0 && idx >= 0 && idx < 16) begin
            if (val != 0) r = r | 16'(1 << idx);
            else          r = r & ~16'(1 << idx);
        end
        return r;
    endfunction

    task automatic drive(input int sel);
        logic [3:0] s;
        s = 4'(sel);
        {if_def.X, if_def.Y, if_def.Z, if_def.W} = s;
        {if_off.X, if_off.Y, if_off.Z, if_off.W} = s;
        {if_one.X, if_one.Y, if_one.Z, if_one.W} = s;
        {if_oor.X, if_oor.Y, if_oor.Z, if_oor.W} = s;
    endtask

    task automatic check_all(input string tag, input int sel, input bit zero);
        logic [15:0] e_def, e_off, e_one, e_oor;
        e_def = zero ? 16'h0 : model(sel, 1, 8, 0);
        e_off = zero ? 16'h0 : model(sel, 0, 8, 0);
        e_one = zero ? 16'h0 : model(sel, 1, 8, 1);
        e_oor = zero ? 16'h0 : model(sel, 1, 20, 0);
        chk({tag, ".def"}, if_def.D, e_def);
        chk({tag, ".off"}, if_off.D, e_off);
        chk({tag, ".one"}, if_one.D, e_one);
        chk({tag, ".oor"}, if_oor.D, e_oor);
`ifdef DEC_FAULT_DETECT_EN
        chk({tag, ".def.flag"}, {15'h0, if_def.fault_flag}, {15'h0, !zero && (e_def != golden_of(sel))});
        chk({tag, ".off.flag"}, {15'h0, if_off.fault_flag}, {15'h0, !zero && (e_off != golden_of(sel))});
        chk({tag, ".one.flag"}, {15'h0, if_one.fault_flag}, {15'h0, !zero && (e_one != golden_of(sel))});
        chk({tag, ".oor.flag"}, {15'h0, if_oor.fault_flag}, {15'h0, !zero && (e_oor != golden_of(sel))});
`endif
    endtask

    task automatic step(input string tag, input int sel);
        @(negedge clk);
        drive(sel);
        @(posedge clk);
        #1;
        check_all(tag, sel, 1'b0);
    endtask

    initial begin
        int sel;
        drive(3);
        repeat (2) @(posedge clk);
        #1;
        check_all("pre", 3, 1'b0);

        // Reset asserted mid-cycle must clear D without a clock edge.
        @(negedge clk);
        #2;
        drive(5);
        rst = 1'b1;
        #1;
        check_all("rst_async", 5, 1'b1);
        @(posedge clk);
        #1;
        check_all("rst_held", 5, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_release", 5, 1'b0);
        chk("rst_release.lit", if_def.D, 16'h0020);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("sweep%0d", i), i);
        end

        step("bnd7", 7);
        chk("bnd7.lit", if_def.D, 16'h0080);
        step("bnd8", 8);
        chk("bnd8.lit", if_def.D, 16'h0000);
        chk("bnd8.off.lit", if_off.D, 16'h0100);
        chk("bnd8.one.lit", if_one.D, 16'h0100);
        step("bnd9", 9);
        chk("bnd9.lit", if_def.D, 16'h0200);
        step("one0", 0);
        chk("one0.lit", if_one.D, 16'h0101);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(15, 0));
            step($sformatf("rand%0d", i), sel);
        end

        step("mid15", 15);
        chk("mid15.lit", if_def.D, 16'h8000);
        #2;
        rst = 1'b1;
        #1;
        check_all("mid_rst", 15, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        step("after_mid", 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
